// File: rtl/ma_filter_mc.sv
// ma_filter_mc: multi-channel, time-multiplexed moving-average filter.
// Each accepted sample updates its own channel's history ring, write pointer,
// fill count and running sum in a single cycle; the result (average, or the raw
// sample during warm-up) lands in one output register with valid/ready.
// Optional feature macro: MA_FILTER_ROUND_EN (round-half-up average, clamped).
module ma_filter_mc #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 5,
    parameter int CHANNELS    = 2,
    parameter int WARMUP_MODE = 0,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_chan,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = WIDTH + $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW:0]   CH_LIM    = (CW + 1)'(CHANNELS);
    localparam logic [SW:0]   AVG_MAX   = {{(SW + 1 - WIDTH){1'b0}}, {WIDTH{1'b1}}};

    // Per-channel state
    logic [WIDTH-1:0] hist_q [CHANNELS][DEPTH];
    logic [WIDTH-1:0] hist_d [CHANNELS][DEPTH];
    logic [SW-1:0]    sum_q  [CHANNELS];
    logic [SW-1:0]    sum_d  [CHANNELS];
    logic [PW-1:0]    wptr_q [CHANNELS];
    logic [PW-1:0]    wptr_d [CHANNELS];
    logic [FW-1:0]    fill_q [CHANNELS];
    logic [FW-1:0]    fill_d [CHANNELS];

    // Output register
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CW-1:0]    out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;

    // Datapath intermediates
    logic             accept_s;
    logic             in_range_s;
    logic [CW-1:0]    ch_s;
    logic             full_s;
    logic [WIDTH-1:0] old_s;
    logic [SW-1:0]    sum_new_s;
    logic [FW-1:0]    fill_new_s;
    logic [WIDTH-1:0] avg_s;
`ifdef MA_FILTER_ROUND_EN
    logic [SW:0]      quo_s;
`endif

    // A new sample may enter only when the output slot frees up this cycle and no clear is in progress
    assign in_ready  = !clr && (!out_valid_q || out_ready);
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

    // Running-sum update and average for the channel addressed by the incoming sample
    always_comb begin
        accept_s   = in_valid && in_ready;
        in_range_s = ({1'b0, in_chan} < CH_LIM);
        ch_s       = in_range_s ? in_chan : '0;
        full_s     = (fill_q[ch_s] == FILL_FULL);
        old_s      = full_s ? hist_q[ch_s][wptr_q[ch_s]] : {WIDTH{1'b0}};
        sum_new_s  = sum_q[ch_s] + SW'(in_data) - SW'(old_s);
        fill_new_s = full_s ? FILL_FULL : (fill_q[ch_s] + {{(FW - 1){1'b0}}, 1'b1});
`ifdef MA_FILTER_ROUND_EN
        quo_s = ({1'b0, sum_new_s} + (SW + 1)'(DEPTH / 2)) / (SW + 1)'(DEPTH);
        if (quo_s > AVG_MAX) begin
            avg_s = {WIDTH{1'b1}};
        end else begin
            avg_s = WIDTH'(quo_s);
        end
`else
        avg_s = WIDTH'(sum_new_s / SW'(DEPTH));
`endif
    end

    // Next-state for channel state and the output register
    always_comb begin
        hist_d      = hist_q;
        sum_d       = sum_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    hist_d[c][k] = {WIDTH{1'b0}};
                end
                sum_d[c]  = {SW{1'b0}};
                wptr_d[c] = {PW{1'b0}};
                fill_d[c] = {FW{1'b0}};
            end
        end else if (accept_s && in_range_s) begin
            hist_d[ch_s][wptr_q[ch_s]] = in_data;
            sum_d[ch_s]  = sum_new_s;
            wptr_d[ch_s] = (wptr_q[ch_s] == PTR_LAST) ? {PW{1'b0}}
                                                      : (wptr_q[ch_s] + {{(PW - 1){1'b0}}, 1'b1});
            fill_d[ch_s] = fill_new_s;
        end else begin
            // channel state holds
            hist_d = hist_q;
        end

        if (accept_s) begin
            // accept implies the previous output, if any, leaves this cycle
            if (in_range_s && ((fill_new_s == FILL_FULL) || (WARMUP_MODE == 0))) begin
                out_valid_d = 1'b1;
                out_data_d  = (fill_new_s == FILL_FULL) ? avg_s : in_data;
                out_chan_d  = in_chan;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q && !out_ready;
        end
    end

    // State registers with synchronous reset that also drops any pending output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    hist_q[c][k] <= {WIDTH{1'b0}};
                end
                sum_q[c]  <= {SW{1'b0}};
                wptr_q[c] <= {PW{1'b0}};
                fill_q[c] <= {FW{1'b0}};
            end
            out_data_q  <= {WIDTH{1'b0}};
            out_chan_q  <= {CW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ma_filter_mc.sv
// Bench for ma_filter_mc. Two instances share stimulus:
//   A: WIDTH=8 DEPTH=5 CHANNELS=2 WARMUP_MODE=0
//   B: WIDTH=8 DEPTH=5 CHANNELS=3 WARMUP_MODE=1 (3 channels so tag 3 is out of range)
// A queue-based window model predicts every output; literal sequences pin the model.
module tb_ma_filter_mc;

    logic       clk = 1'b0;
    logic       rst, clr, out_ready, a_valid, b_valid;
    logic [7:0] in_data;
    logic [1:0] in_chan;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [0:0] a_out_chan;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_out_chan;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: last samples per (dut, channel), expected and observed outputs (chan*256+data)
    int hq   [2][4][$];
    int exp_q[2][$];
    int got  [2][$];
    bit stall_prev [2];
    int prev_val   [2];

`ifdef MA_FILTER_ROUND_EN
    localparam int RND_EXP = 2;
`else
    localparam int RND_EXP = 1;
`endif

    always #5 clk = ~clk;

    ma_filter_mc #(.WIDTH(8), .DEPTH(5), .CHANNELS(2), .WARMUP_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_chan(in_chan[0:0]), .in_valid(a_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(out_ready)
    );

    ma_filter_mc #(.WIDTH(8), .DEPTH(5), .CHANNELS(3), .WARMUP_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_chan(in_chan), .in_valid(b_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input int got_v, input int exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got_v, exp_v, $time);
        end
    endtask

    // Moving average over the last 5 samples of one channel, straight from the definition
    task automatic model_accept(input int d, input int ch, input int x);
        int nch, s, avg;
        nch = (d == 0) ? 2 : 3;
        if (ch < nch) begin
            hq[d][ch].push_back(x);
            if (hq[d][ch].size() > 5) void'(hq[d][ch].pop_front());
            if (hq[d][ch].size() == 5) begin
                s = 0;
                foreach (hq[d][ch][i]) s += hq[d][ch][i];
`ifdef MA_FILTER_ROUND_EN
                avg = (s + 2) / 5;
                if (avg > 255) avg = 255;
`else
                avg = s / 5;
`endif
                exp_q[d].push_back(ch * 256 + avg);
            end else if (d == 0) begin
                exp_q[d].push_back(ch * 256 + x);
            end
        end
    endtask

    task automatic check_out(input int d, input bit ov, input int val);
        int e;
        if (stall_prev[d]) check($sformatf("hold_stable_%0d", d), val, prev_val[d]);
        if (ov && out_ready) begin
            if (exp_q[d].size() == 0) begin
                check($sformatf("unexpected_out_%0d", d), val, -1);
            end else begin
                e = exp_q[d].pop_front();
                check($sformatf("out_%0d", d), val, e);
            end
            got[d].push_back(val);
        end
        stall_prev[d] = ov && !out_ready;
        prev_val[d]   = val;
    endtask

    // Single compare process: checks outputs and advances the model each cycle
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                stall_prev[d] = 1'b0;
                for (int c = 0; c < 4; c++) hq[d][c].delete();
            end
        end else begin
            check_out(0, a_out_valid, int'(a_out_chan) * 256 + int'(a_out_data));
            check_out(1, b_out_valid, int'(b_out_chan) * 256 + int'(b_out_data));
            if (a_valid && a_in_ready) model_accept(0, int'(in_chan[0]), int'(in_data));
            if (b_valid && b_in_ready) model_accept(1, int'(in_chan), int'(in_data));
            if (clr) begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < 4; c++) hq[d][c].delete();
            end
        end
    end

    // mask bit0 -> A, bit1 -> B; returns one cycle after acceptance
    task automatic send(input bit [1:0] mask, input int ch, input int x);
        int n;
        bit done;
        in_chan = 2'(ch);
        in_data = 8'(x);
        a_valid = mask[0];
        b_valid = mask[1];
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if ((!mask[0] || a_in_ready) && (!mask[1] || b_in_ready)) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 20) begin
                    check("accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fresh();
        idle(2);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        got[0].delete();
        got[1].delete();
    endtask

    task automatic check_seq(input int d, input string name, input int n,
                             input int v0, input int v1, input int v2,
                             input int v3, input int v4, input int v5);
        int v[6];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3; v[4] = v4; v[5] = v5;
        check({name, "_len"}, got[d].size(), n);
        for (int i = 0; i < n; i++)
            if (i < got[d].size()) check($sformatf("%s_%0d", name, i), got[d][i], v[i]);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; in_data = 8'd0; in_chan = 2'd0;

        // 1. Reset
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_data",  a_out_data, 0);
        check("rst_a_chan",  a_out_chan, 0);
        check("rst_a_ready", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_data",  b_out_data, 0);
        check("rst_b_ready", b_in_ready, 1);
        @(posedge clk); #1;

        // 2. Warm-up and steady state
        fresh();
        for (int i = 1; i <= 6; i++) send(2'b11, 0, 10 * i);
        idle(2);
        check_seq(0, "warm_a", 6, 10, 20, 30, 40, 30, 40);
        check_seq(1, "warm_b", 2, 30, 40, 0, 0, 0, 0);

        // 3. Channel interleave, full-scale channel 1
        fresh();
        for (int i = 1; i <= 5; i++) begin
            send(2'b11, 1, 255);
            send(2'b11, 0, 10 * i);
        end
        idle(2);
        check("ilv_a_len", got[0].size(), 10);
        if (got[0].size() == 10) begin
            check("ilv_a_ch1_final", got[0][8], 256 + 255);
            check("ilv_a_ch0_final", got[0][9], 30);
        end
        check_seq(1, "ilv_b", 2, 256 + 255, 30, 0, 0, 0, 0);

        // 4. Backpressure on A
        fresh();
        send(2'b01, 0, 10);
        send(2'b01, 0, 20);
        in_data = 8'd30; in_chan = 2'd0; a_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", a_in_ready, 0);
            check("bp_out_valid", a_out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        a_valid = 1'b0;
        send(2'b01, 0, 30);
        send(2'b01, 0, 40);
        send(2'b01, 0, 50);
        idle(2);
        check_seq(0, "bp", 5, 10, 20, 30, 40, 30, 0);

        // 5. Rounding
        fresh();
        send(2'b11, 0, 1); send(2'b11, 0, 1); send(2'b11, 0, 1);
        send(2'b11, 0, 1); send(2'b11, 0, 4);
        idle(2);
        check_seq(0, "rnd_a", 5, 1, 1, 1, 1, RND_EXP, 0);
        check_seq(1, "rnd_b", 1, RND_EXP, 0, 0, 0, 0, 0);

        // 6. Clear restarts warm-up; pending output still delivered
        fresh();
        send(2'b11, 0, 10); send(2'b11, 0, 20); send(2'b11, 0, 30);
        clr = 1'b1;
        @(negedge clk);
        check("clr_a_ready", a_in_ready, 0);
        check("clr_b_ready", b_in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        send(2'b11, 0, 50); send(2'b11, 0, 50); send(2'b11, 0, 50);
        send(2'b11, 0, 50); send(2'b11, 0, 60);
        idle(2);
        check("clr_a_len", got[0].size(), 8);
        if (got[0].size() == 8) begin
            check("clr_a_pending", got[0][2], 30);
            check("clr_a_restart", got[0][3], 50);
            check("clr_a_avg",     got[0][7], 52);
        end
        check_seq(1, "clr_b", 1, 52, 0, 0, 0, 0, 0);

        // Out-of-range tag on B: accepted, no output
        send(2'b10, 3, 99);
        idle(3);
        check("oor_b_len", got[1].size(), 1);

        check("drain_a", exp_q[0].size(), 0);
        check("drain_b", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
